// File: rtl/multicycle_alu.sv
// multicycle_alu: parametrised multi-cycle ALU with registered result/flags
// and a start/busy/done handshake toward the controller FSM.
//
// Single-cycle ops (ADD, AND, OR, XOR, SUB, shifts by 0) complete on the edge
// that samples start. Shifts move one bit per cycle; MUL is a shift-add
// multiplier that retires one multiplier bit per cycle.
//
// Build option: define MULTICYCLE_ALU_MUL_EN to include the iterative
// multiplier. Without it, op 111 completes in one cycle with result 0 and
// flags {C,Z,N} = 3'b010, and no multiplier/accumulator logic is built.

module multicycle_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       czn,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [2:0]       czn_reg, czn_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] sh_reg, sh_next;     // shift working register
  logic             shl_reg, shl_next;   // 1 = shift left, 0 = shift right
  logic [CNTW-1:0]  cnt_reg, cnt_next;   // iterations remaining

  // Completion bundle: any path that finishes an operation sets these.
  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;

  // Operand-level arithmetic for the single-cycle ops; the extra MSB is the
  // carry (ADD) or the borrow (SUB, wraps to 1 when a < b + cin).
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [CNTW-1:0]  shift_amt;

  assign add_ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_ext   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  // Only the low CNTW-1 bits of b form the shift count (0 .. WIDTH-1).
  assign shift_amt = {1'b0, b[CNTW-2:0]};

  // One-bit shift step; sh_out is the bit leaving the register this cycle.
  logic [WIDTH-1:0] sh_step;
  logic             sh_out;

  assign sh_step = shl_reg ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
  assign sh_out  = shl_reg ? sh_reg[WIDTH-1] : sh_reg[0];

`ifdef MULTICYCLE_ALU_MUL_EN
  localparam logic [CNTW-1:0] CNT_MUL = CNTW'(WIDTH);

  // Accumulator holds {partial product high half, remaining multiplier bits}.
  // Each cycle the multiplicand is added into the high half when the current
  // multiplier LSB is set, then the whole accumulator moves right one bit.
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     mul_sum;

  // Partial product: multiplicand gated by the current multiplier bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = mcand_reg[gi] & acc_reg[0];
    end
  endgenerate

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
`endif

  // Next-state, datapath and completion logic.
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    czn_next    = czn_reg;
    done_next   = 1'b0;
    sh_next     = sh_reg;
    shl_next    = shl_reg;
    cnt_next    = cnt_reg;
`ifdef MULTICYCLE_ALU_MUL_EN
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
`endif
    fin         = 1'b0;
    fin_res     = '0;
    fin_c       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD: begin
              fin     = 1'b1;
              fin_res = add_ext[WIDTH-1:0];
              fin_c   = add_ext[WIDTH];
            end
            OP_AND: begin
              fin     = 1'b1;
              fin_res = a & b;
            end
            OP_OR: begin
              fin     = 1'b1;
              fin_res = a | b;
            end
            OP_XOR: begin
              fin     = 1'b1;
              fin_res = a ^ b;
            end
            OP_SUB: begin
              fin     = 1'b1;
              fin_res = sub_ext[WIDTH-1:0];
              fin_c   = sub_ext[WIDTH];
            end
            OP_SHL, OP_SHR: begin
              if (shift_amt == '0) begin
                // Zero-length shift passes a through with no carry.
                fin     = 1'b1;
                fin_res = a;
              end else begin
                sh_next    = a;
                shl_next   = (op == OP_SHL);
                cnt_next   = shift_amt;
                state_next = ST_SHIFT;
              end
            end
            OP_MUL: begin
`ifdef MULTICYCLE_ALU_MUL_EN
              acc_next   = {{WIDTH{1'b0}}, b};
              mcand_next = a;
              cnt_next   = CNT_MUL;
              state_next = ST_MUL;
`else
              // Multiplier not built: retire immediately with a zero result.
              fin     = 1'b1;
              fin_res = '0;
`endif
            end
            default: ;
          endcase
        end
      end

      ST_SHIFT: begin
        sh_next  = sh_step;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          fin     = 1'b1;
          fin_res = sh_step;
          fin_c   = sh_out;
        end
      end

`ifdef MULTICYCLE_ALU_MUL_EN
      ST_MUL: begin
        acc_next = acc_step;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          fin     = 1'b1;
          fin_res = acc_step[WIDTH-1:0];
          fin_c   = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
`endif

      default: state_next = ST_IDLE;
    endcase

    // Result and flags are written only when an operation retires.
    if (fin) begin
      result_next = fin_res;
      czn_next    = {fin_c, (fin_res == '0), fin_res[WIDTH-1]};
      done_next   = 1'b1;
      state_next  = ST_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      czn_reg    <= 3'b000;
      done_reg   <= 1'b0;
      sh_reg     <= '0;
      shl_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      result_reg <= result_next;
      czn_reg    <= czn_next;
      done_reg   <= done_next;
      sh_reg     <= sh_next;
      shl_reg    <= shl_next;
      cnt_reg    <= cnt_next;
    end
  end

`ifdef MULTICYCLE_ALU_MUL_EN
  // Multiplier accumulator and latched multiplicand.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
    end
  end
`endif

  assign result = result_reg;
  assign czn    = czn_reg;
  assign done   = done_reg;
  assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed-vector bench for multicycle_alu (WIDTH=8).
// The driver pushes hand-computed expectations into a scoreboard queue; a
// monitor pops and compares whenever done is seen, and tracks busy per cycle.
// Honours MULTICYCLE_ALU_MUL_EN for the op-111 expectations.

module tb_multicycle_alu;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

`ifdef MULTICYCLE_ALU_MUL_EN
  localparam int         MUL_LAT  = 8;
  localparam logic [7:0] MUL1_RES = 8'h00;
  localparam logic [2:0] MUL1_CZN = 3'b110;
  localparam logic [7:0] MUL2_RES = 8'h15;
  localparam logic [2:0] MUL2_CZN = 3'b000;
  localparam logic [7:0] MUL3_RES = 8'h01;
  localparam logic [2:0] MUL3_CZN = 3'b100;
`else
  localparam int         MUL_LAT  = 0;
  localparam logic [7:0] MUL1_RES = 8'h00;
  localparam logic [2:0] MUL1_CZN = 3'b010;
  localparam logic [7:0] MUL2_RES = 8'h00;
  localparam logic [2:0] MUL2_CZN = 3'b010;
  localparam logic [7:0] MUL3_RES = 8'h00;
  localparam logic [2:0] MUL3_CZN = 3'b010;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] result;
  logic [2:0] czn;
  logic       busy;
  logic       done;

  multicycle_alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .result (result),
    .czn    (czn),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [2:0] czn;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_lo = 0;
  int   busy_hi = -1;

  // Present one request for a cycle. Called #1 after an edge; returns #1
  // after the edge that samples start. With push set, the expected result is
  // queued to arrive lat edges after that sampling edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ci, input bit push,
                       input logic [7:0] er, input logic [2:0] ec, input int lat);
    exp_t e;
    int   acc_cyc;
    acc_cyc = cyc + 1;
    op = o; a = aa; b = bb; cin = ci; start = 1'b1;
    if (push) begin
      e.res = er; e.czn = ec; e.cyc = acc_cyc + lat;
      sb.push_back(e);
    end
    if (lat > 0) begin
      busy_lo = acc_cyc;
      busy_hi = acc_cyc + lat - 1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble operands: nothing after acceptance may depend on them.
    op = 3'b011; a = 8'hA5; b = 8'h5A; cin = 1'b1;
  endtask

  // Advance until done is visible (returns inside the done cycle).
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout cyc=%0d got done=%b required done=1", cyc, done);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end else begin
      $display("ok %s = %0h", name, got);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; cin = 1'b0;

    // Monitor: compares every done against the scoreboard, busy every cycle.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          logic exp_busy;
          exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
          n_cmp++;
          if (busy !== exp_busy) begin
            n_bad++;
            $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
          end
          if (done === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
              n_bad++;
              $display("FAIL done_unexpected cyc=%0d got result=%02h czn=%03b required no done",
                       cyc, result, czn);
            end else begin
              exp_t e;
              e = sb.pop_front();
              if (result !== e.res || czn !== e.czn || cyc != e.cyc) begin
                n_bad++;
                $display("FAIL txn got result=%02h czn=%03b cyc=%0d required result=%02h czn=%03b cyc=%0d",
                         result, czn, cyc, e.res, e.czn, e.cyc);
              end else begin
                $display("txn result=%02h czn=%03b cyc=%0d", result, czn, cyc);
              end
            end
          end
        end
      end
    join_none

    idle(3);
    check("reset_result", 32'(result), 32'h00);
    check("reset_czn",    32'(czn),    32'h0);
    check("reset_busy",   32'(busy),   32'h0);
    check("reset_done",   32'(done),   32'h0);
    rst = 1'b0;

    // Single-cycle ops, issued back-to-back.
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 3'b110, 0);
    issue(OP_SUB, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 3'b101, 0);
    issue(OP_XOR, 8'hF0, 8'hF0, 1'b0, 1'b1, 8'h00, 3'b010, 0);
    issue(OP_AND, 8'hCC, 8'hAA, 1'b0, 1'b1, 8'h88, 3'b001, 0);
    issue(OP_OR,  8'h0C, 8'h30, 1'b0, 1'b1, 8'h3C, 3'b000, 0);
    issue(OP_ADD, 8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 3'b001, 0);
    issue(OP_SUB, 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 3'b101, 0);
    idle(2);

    // Shifts: multi-cycle, zero-length, and count taken from b[2:0] only.
    issue(OP_SHL, 8'h30, 8'h03, 1'b0, 1'b1, 8'h80, 3'b101, 3);
    wait_done();
    issue(OP_SHR, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 3'b000, 0);
    issue(OP_SHR, 8'h81, 8'h01, 1'b0, 1'b1, 8'h40, 3'b100, 1);
    wait_done();
    issue(OP_SHL, 8'h01, 8'h07, 1'b0, 1'b1, 8'h80, 3'b001, 7);
    wait_done();
    issue(OP_SHR, 8'hF0, 8'h05, 1'b0, 1'b1, 8'h07, 3'b100, 5);
    wait_done();
    issue(OP_SHL, 8'h81, 8'h09, 1'b0, 1'b1, 8'h02, 3'b100, 1);
    wait_done();

    // Multiply (or its single-cycle stand-in when not built).
    issue(OP_MUL, 8'h10, 8'h10, 1'b0, 1'b1, MUL1_RES, MUL1_CZN, MUL_LAT);
    wait_done();
    issue(OP_MUL, 8'h07, 8'h03, 1'b0, 1'b1, MUL2_RES, MUL2_CZN, MUL_LAT);
    wait_done();
    issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b1, MUL3_RES, MUL3_CZN, MUL_LAT);
    wait_done();
    idle(1);

    // start while busy must be ignored.
    issue(OP_SHL, 8'h03, 8'h04, 1'b0, 1'b1, 8'h30, 3'b000, 4);
    issue(OP_ADD, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 3'b000, 0);
    wait_done();
`ifdef MULTICYCLE_ALU_MUL_EN
    issue(OP_MUL, 8'h07, 8'h03, 1'b0, 1'b1, 8'h15, 3'b000, 8);
    idle(2);
    issue(OP_MUL, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 3'b000, 0);
    wait_done();
`endif
    // Accepted in the done cycle, then leaves a nonzero result for the reset test.
    issue(OP_ADD, 8'h10, 8'h20, 1'b1, 1'b1, 8'h31, 3'b000, 0);
    idle(1);

    // Reset two cycles into a 5-bit shift: aborted, no done.
    issue(OP_SHL, 8'h01, 8'h05, 1'b0, 1'b0, 8'h00, 3'b000, 5);
    idle(1);
    rst = 1'b1;
    busy_hi = -1;
    @(posedge clk);
    #1;
    check("abort_result", 32'(result), 32'h00);
    check("abort_czn",    32'(czn),    32'h0);
    check("abort_busy",   32'(busy),   32'h0);
    check("abort_done",   32'(done),   32'h0);
    rst = 1'b0;
    idle(8);

    issue(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 3'b000, 0);
    idle(4);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
